// File: rtl/adc_serial_sampler.sv
// Serial-ADC capture engine: track window, 16-period SCLK/CS_n frame, MSB-first shift-in.
// Optional ADC_OVERSAMPLE_EN averages 2**AVG_LOG2 conversions per request.
module adc_serial_sampler #(
    parameter int DATA_BITS    = 12,
    parameter int OUT_BITS     = 8,
    parameter int OUT_LSB      = 0,
    parameter int SCLK_HALF    = 1,
    parameter int TRACK_CYCLES = 14,
    parameter int LEAD_ZEROS   = 3,
    parameter int AVG_LOG2     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adc_capture_start,
    output logic                adc_capture_done,
    output logic                data_valid,
    input  logic                data_ready,
    output logic [OUT_BITS-1:0] pixel_data,
    output logic                busy,
    output logic                overrun,
    input  logic                sdata,
    output logic                sclk,
    output logic                cs_n
);

    localparam int TW      = (TRACK_CYCLES > 1) ? $clog2(TRACK_CYCLES) : 1;
    localparam int SW      = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int TRAIL_P = 16 - LEAD_ZEROS - DATA_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRACK,
        S_ZEROS,
        S_READ,
        S_TRAIL,
        S_HOLD
    } state_t;

    state_t               r_state, w_state_n;
    logic [TW-1:0]        r_timer, w_timer_n;
    logic [SW-1:0]        r_sub, w_sub_n;
    logic [4:0]           r_hp, w_hp_n;
    logic [DATA_BITS-1:0] r_shift, w_shift_n;
    logic                 r_sclk, w_sclk_n;
    logic                 r_cs_n, w_cs_n_n;
    logic                 r_done, w_done_n;
    logic                 r_valid, w_valid_n;
    logic [OUT_BITS-1:0]  r_pix, w_pix_n;
    logic                 r_busy;
    logic                 r_overrun, w_overrun_n;
    logic                 r_pending, w_pending_n;
    logic                 w_in_frame, w_sub_end, w_per_end;
    logic                 w_accept, w_frame_end, w_req, w_final;
    logic [3:0]           w_per;

`ifdef ADC_OVERSAMPLE_EN
    localparam int AW = DATA_BITS + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    logic [AW-1:0] r_acc, w_acc_n, w_sum, w_avg;
    logic [CW-1:0] r_conv, w_conv_n;
    assign w_sum   = r_acc + AW'(w_shift_n);
    assign w_avg   = w_sum >> AVG_LOG2;
    assign w_final = (r_conv == CW'((1 << AVG_LOG2) - 1));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^AVG_LOG2;
    assign w_final      = 1'b1;
`endif

    assign w_in_frame = r_state inside {S_ZEROS, S_READ, S_TRAIL};
    assign w_sub_end  = (r_sub == SW'(SCLK_HALF - 1));
    assign w_per_end  = w_in_frame && w_sub_end && r_hp[0];
    assign w_per      = r_hp[4:1];
    assign w_accept   = (r_state == S_HOLD) && data_ready;
    // sample in the last clk of each high phase, just before the falling edge
    assign w_shift_n  = ((r_state == S_READ) && w_per_end)
                      ? {r_shift[DATA_BITS-2:0], sdata} : r_shift;

    always_comb begin
        w_state_n   = r_state;
        w_timer_n   = r_timer;
        w_sub_n     = r_sub;
        w_hp_n      = r_hp;
        w_sclk_n    = r_sclk;
        w_cs_n_n    = r_cs_n;
        w_done_n    = 1'b0;
        w_valid_n   = r_valid;
        w_pix_n     = r_pix;
        w_overrun_n = 1'b0;
        w_pending_n = r_pending;
        w_frame_end = 1'b0;
        w_req       = 1'b0;
`ifdef ADC_OVERSAMPLE_EN
        w_acc_n     = r_acc;
        w_conv_n    = r_conv;
`endif
        if (adc_capture_start && (r_state != S_IDLE) && !w_accept) begin
            if (r_pending) w_overrun_n = 1'b1;
            else           w_pending_n = 1'b1;
        end

        unique case (r_state)
            S_IDLE: w_req = adc_capture_start;
            S_TRACK: begin
                w_timer_n = r_timer - 1'b1;
                if (r_timer == '0) begin
                    w_state_n = (LEAD_ZEROS == 0) ? S_READ : S_ZEROS;
                    w_cs_n_n  = 1'b0;
                    w_sclk_n  = 1'b0;
                    w_sub_n   = '0;
                    w_hp_n    = '0;
                    w_done_n  = w_final;
                end
            end
            S_ZEROS, S_READ, S_TRAIL: begin
                if (w_sub_end) begin
                    w_sub_n  = '0;
                    w_hp_n   = r_hp + 1'b1;
                    w_sclk_n = ~r_sclk;
                end else begin
                    w_sub_n  = r_sub + 1'b1;
                end
                if (w_per_end) begin
                    if (r_state == S_ZEROS && w_per == 4'(LEAD_ZEROS - 1))
                        w_state_n = S_READ;
                    if (r_state == S_READ
                        && w_per == 4'(LEAD_ZEROS + DATA_BITS - 1)) begin
                        if (TRAIL_P == 0) w_frame_end = 1'b1;
                        else              w_state_n   = S_TRAIL;
                    end
                    if (r_state == S_TRAIL && w_per == 4'd15)
                        w_frame_end = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_accept) begin
                    w_valid_n = 1'b0;
                    // a start on the accept cycle is served immediately
                    if (r_pending || adc_capture_start) begin
                        w_req       = 1'b1;
                        w_pending_n = r_pending && adc_capture_start;
                    end else begin
                        w_state_n   = S_IDLE;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        if (w_frame_end) begin
            w_cs_n_n = 1'b1;
            w_sclk_n = 1'b1;
            if (w_final) begin
                w_state_n = S_HOLD;
                w_valid_n = 1'b1;
`ifdef ADC_OVERSAMPLE_EN
                w_pix_n   = w_avg[OUT_LSB+OUT_BITS-1:OUT_LSB];
`else
                w_pix_n   = w_shift_n[OUT_LSB+OUT_BITS-1:OUT_LSB];
`endif
            end else begin
                w_state_n = S_TRACK;
                w_timer_n = TW'(TRACK_CYCLES - 1);
`ifdef ADC_OVERSAMPLE_EN
                w_conv_n  = r_conv + 1'b1;
                w_acc_n   = w_sum;
`endif
            end
        end

        if (w_req) begin
            w_state_n = S_TRACK;
            w_timer_n = TW'(TRACK_CYCLES - 1);
`ifdef ADC_OVERSAMPLE_EN
            w_acc_n   = '0;
            w_conv_n  = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_sub     <= '0;
            r_hp      <= '0;
            r_shift   <= '0;
            r_sclk    <= 1'b1;
            r_cs_n    <= 1'b1;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_pix     <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_pending <= 1'b0;
`ifdef ADC_OVERSAMPLE_EN
            r_acc     <= '0;
            r_conv    <= '0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_timer   <= w_timer_n;
            r_sub     <= w_sub_n;
            r_hp      <= w_hp_n;
            r_shift   <= w_shift_n;
            r_sclk    <= w_sclk_n;
            r_cs_n    <= w_cs_n_n;
            r_done    <= w_done_n;
            r_valid   <= w_valid_n;
            r_pix     <= w_pix_n;
            r_busy    <= (w_state_n != S_IDLE);
            r_overrun <= w_overrun_n;
            r_pending <= w_pending_n;
`ifdef ADC_OVERSAMPLE_EN
            r_acc     <= w_acc_n;
            r_conv    <= w_conv_n;
`endif
        end
    end

    assign adc_capture_done = r_done;
    assign data_valid       = r_valid;
    assign pixel_data       = r_pix;
    assign busy             = r_busy;
    assign overrun          = r_overrun;
    assign sclk             = r_sclk;
    assign cs_n             = r_cs_n;

endmodule

// File: tb/tb_adc_serial_sampler.sv
// Directed bench for adc_serial_sampler: frame timing, slicing, handshake,
// pending/overrun, mid-frame reset; averaging run when ADC_OVERSAMPLE_EN is set.
module tb_adc_serial_sampler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b0;

    logic       done, valid, busy, ovr, sclk, cs_n, sdata;
    logic [7:0] pix;
    logic       done_h, valid_h, busy_h, ovr_h, sclk_h, cs_n_h;
    logic [7:0] pix_h;
    logic       done8, valid8, busy8, ovr8, sclk8, cs_n8, sdata8;
    logic [7:0] pix8;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    adc_serial_sampler dut (
        .clk(clk), .reset(reset), .adc_capture_start(start),
        .adc_capture_done(done), .data_valid(valid), .data_ready(ready),
        .pixel_data(pix), .busy(busy), .overrun(ovr),
        .sdata(sdata), .sclk(sclk), .cs_n(cs_n)
    );

    adc_serial_sampler #(.OUT_LSB(4)) dut_hi (
        .clk(clk), .reset(reset), .adc_capture_start(start),
        .adc_capture_done(done_h), .data_valid(valid_h), .data_ready(ready),
        .pixel_data(pix_h), .busy(busy_h), .overrun(ovr_h),
        .sdata(sdata), .sclk(sclk_h), .cs_n(cs_n_h)
    );

    adc_serial_sampler #(.DATA_BITS(8)) dut8 (
        .clk(clk), .reset(reset), .adc_capture_start(start),
        .adc_capture_done(done8), .data_valid(valid8), .data_ready(ready),
        .pixel_data(pix8), .busy(busy8), .overrun(ovr8),
        .sdata(sdata8), .sclk(sclk8), .cs_n(cs_n8)
    );

    // ADC model: count SCLK falls inside CS_n low; period p = fall-1,
    // word MSB appears in period 3 (after three leading zeros)
    logic [11:0] word;
    logic [7:0]  word8;
    int   fall = 0;
    int   fall8 = 0;
    logic ps = 1'b1;
    logic ps8 = 1'b1;
    logic pcs_m = 1'b1;

    always @(posedge clk) begin
        #1;
        if (cs_n) fall = 0;
        else if (ps && !sclk) fall = fall + 1;
        if (cs_n8) fall8 = 0;
        else if (ps8 && !sclk8) fall8 = fall8 + 1;
`ifdef ADC_OVERSAMPLE_EN
        if (cs_n && !pcs_m) begin
            word  = word + 12'd1;
            word8 = word8 + 8'd1;
        end
`endif
        ps    = sclk;
        ps8   = sclk8;
        pcs_m = cs_n;
    end

    always_comb begin
        sdata = 1'b0;
        if (fall >= 4 && fall <= 15) sdata = word[4'(15 - fall)];
        sdata8 = 1'b0;
        if (fall8 >= 4 && fall8 <= 11) sdata8 = word8[3'(11 - fall8)];
    end

    int first_low, low_cnt, falls, done_cnt, done_at, vrise;
    int low8, falls8, vrise8, n_res, ovr_cnt, ovr_at, frames;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // n cycles; extra start pulses presented after cycles s2 and s3
    task automatic run(input int n, input int s2, input int s3);
        logic p, p8, pc;
        p = sclk; p8 = sclk8; pc = cs_n;
        first_low = -1; low_cnt = 0; falls = 0; done_cnt = 0; done_at = -1;
        vrise = -1; low8 = 0; falls8 = 0; vrise8 = -1; n_res = 0;
        ovr_cnt = 0; ovr_at = -1; frames = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            start = (i == s2) || (i == s3);
            if (!cs_n) begin
                if (first_low < 0) first_low = i;
                low_cnt++;
                if (p && !sclk) falls++;
                if (pc) frames++;
            end
            if (!cs_n8) begin
                low8++;
                if (p8 && !sclk8) falls8++;
            end
            if (done) begin done_cnt++; done_at = i; end
            if (valid && vrise < 0) vrise = i;
            if (valid8 && vrise8 < 0) vrise8 = i;
            if (valid && ready) n_res++;
            if (ovr) begin ovr_cnt++; ovr_at = i; end
            p = sclk; p8 = sclk8; pc = cs_n;
        end
    endtask

    initial begin
        logic stable;
        word  = 12'hA5C;
        word8 = 8'h3C;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pix", 32'(pix), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        reset = 1'b0;
        tick();

`ifdef ADC_OVERSAMPLE_EN
        word  = 12'd100;
        word8 = 8'd100;
        start = 1'b1;
        run(200, 0, 0);
        chk("os_frames", 32'(frames), 32'd4);
        chk("os_done_cnt", 32'(done_cnt), 32'd1);
        chk("os_done_at", 32'(done_at), 32'd153);
        chk("os_vrise", 32'(vrise), 32'd185);
        chk("os_pix", 32'(pix), 32'd101);
        chk("os_pix_hi", 32'(pix_h), 32'd6);
        chk("os_pix8", 32'(pix8), 32'd101);
        chk("os_busy", 32'(busy), 32'd1);
`else
        // single conversion, defaults
        start = 1'b1;
        run(60, 0, 0);
        chk("t1_first_low", 32'(first_low), 32'd15);
        chk("t1_low_cnt", 32'(low_cnt), 32'd32);
        chk("t1_falls", 32'(falls), 32'd16);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_done_at", 32'(done_at), 32'd15);
        chk("t1_vrise", 32'(vrise), 32'd47);
        chk("t1_pix", 32'(pix), 32'h5C);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ovr", 32'(ovr_cnt), 32'd0);
        chk("t2_pix_hi", 32'(pix_h), 32'hA5);
        chk("t2_pix8", 32'(pix8), 32'h3C);
        chk("t2_low8", 32'(low8), 32'd32);
        chk("t2_falls8", 32'(falls8), 32'd16);
        chk("t2_vrise8", 32'(vrise8), 32'd47);

        // backpressure, with a start queued during hold
        stable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            start = (i == 5);
            if (!(valid && pix == 8'h5C && cs_n && sclk)) stable = 1'b0;
        end
        chk("t3_stable", 32'(stable), 32'd1);
        chk("t3_no_ovr", 32'(ovr), 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t3_acc_valid", 32'(valid), 32'd0);
        chk("t3_acc_busy", 32'(busy), 32'd1);
        chk("t3_acc_cs_n", 32'(cs_n), 32'd1);
        run(60, 0, 0);
        chk("t3_first_low", 32'(first_low), 32'd14);
        chk("t3_low_cnt", 32'(low_cnt), 32'd32);
        chk("t3_vrise", 32'(vrise), 32'd46);
        chk("t3_pix", 32'(pix), 32'h5C);

        // drain to idle, then three starts within one request
        ready = 1'b1;
        tick();
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_valid", 32'(valid), 32'd0);
        start = 1'b1;
        run(130, 20, 25);
        chk("t4_results", 32'(n_res), 32'd2);
        chk("t4_ovr_cnt", 32'(ovr_cnt), 32'd1);
        chk("t4_ovr_at", 32'(ovr_at), 32'd26);
        chk("t4_done_cnt", 32'(done_cnt), 32'd2);
        chk("t4_vrise", 32'(vrise), 32'd47);
        chk("t4_pix", 32'(pix), 32'h5C);
        chk("t4_end_busy", 32'(busy), 32'd0);

        // reset in the middle of READ, then a clean frame
        ready = 1'b0;
        start = 1'b1;
        run(25, 0, 0);
        chk("t5_mid_cs_n", 32'(cs_n), 32'd0);
        reset = 1'b1;
        tick();
        chk("t5_rst_cs_n", 32'(cs_n), 32'd1);
        chk("t5_rst_sclk", 32'(sclk), 32'd1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(valid), 32'd0);
        reset = 1'b0;
        tick();
        start = 1'b1;
        run(60, 0, 0);
        chk("t5_first_low", 32'(first_low), 32'd15);
        chk("t5_low_cnt", 32'(low_cnt), 32'd32);
        chk("t5_falls", 32'(falls), 32'd16);
        chk("t5_vrise", 32'(vrise), 32'd47);
        chk("t5_pix", 32'(pix), 32'h5C);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
